mem_stage: RTL and testbench

//  MEM pipeline stage, directly downstream of EX.
//  - Registers EX results and runs one load or store per instruction on a req/ack data bus.
//  - Performs byte-lane steering for LB/SB.
//  - Stalls the upstream pipeline while a bus access is outstanding.
//  - Presents registered write-back outputs, which also serve as the MEM->EX forwarding source.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_lane_fmt.sv | 43 ++++
 rtl/mem_stage.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the MEM stage (FSM states, byte enables, lane ids).
// Pure declarations plus a byte sign-extension helper; no logic of its own.
// Imported by mem_stage and mem_lane_fmt.
package mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: store byte-lane replication / byte-enable generation and load byte extract.
// Purely combinational, zero latency.
// No flow control; the caller decides when the outputs are sampled.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic        st_byte,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic        ld_byte,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0] ld_sel;

  // Store side: a byte store replicates the low byte on every lane and enables only one.
  always_comb begin
    st_be    = BE_WORD;
    st_wdata = st_data;
    if (st_byte) begin
      st_be    = BE_BYTE0 << st_lane;
      st_wdata = {4{st_data[7:0]}};
    end
  end

  // Load side: pick the addressed byte and sign-extend it; word loads pass straight through.
  always_comb begin
    ld_sel = ld_rdata[7:0];
    case (ld_lane)
      LANE0:   ld_sel = ld_rdata[7:0];
      LANE1:   ld_sel = ld_rdata[15:8];
      LANE2:   ld_sel = ld_rdata[23:16];
      LANE3:   ld_sel = ld_rdata[31:24];
      default: ld_sel = ld_rdata[7:0];
    endcase
    ld_data = ld_byte ? sext8(ld_sel) : ld_rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage running one load/store per instruction on a req/ack bus.
// Latency: 1 cycle for non-memory ops; memory ops write back the cycle after bus_ack.
// Backpressure: mem_stall holds upstream while an access is open; MEM_ALIGN_CHECK_EN enables misalign trapping.
module mem_stage
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_mem_data,
  input  logic        ex_load_byte,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_wreg,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_wreg,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misalign
);

  // The access is aborted at the end of the MAX_WAIT-th ACCESS cycle without ack.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        is_mem, bad_align, capture, start_access, direct, timeout, acc_done;
  logic        op_byte, op_reg_write;
  logic [1:0]  op_lane;
  logic [4:0]  op_wreg;
  logic [31:0] op_result;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, ld_data;
  // A non-access op captured on the ack edge collides with the finishing access's
  // write-back; it is parked here for one cycle instead of introducing a stall.
  logic        pend_vld, pend_reg_write;
  logic [4:0]  pend_wreg;
  logic [31:0] pend_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic        pend_mis;
`endif

  assign is_mem = ex_mem_read | ex_mem_write;
`ifdef MEM_ALIGN_CHECK_EN
  assign bad_align = is_mem && !ex_load_byte && (ex_result[1:0] != LANE0);
`else
  assign bad_align = 1'b0;
`endif
  assign capture      = ex_valid && !mem_stall;
  assign start_access = capture && is_mem && !bad_align;
  assign direct       = capture && !start_access;
  assign timeout      = (state == ACCESS) && !bus_ack && (wait_cnt == LAST_WAIT);
  assign acc_done     = (state == ACCESS) && (bus_ack || timeout);

  mem_lane_fmt u_fmt (
    .st_byte  (ex_load_byte),
    .st_lane  (ex_result[1:0]),
    .st_data  (ex_mem_data),
    .st_be    (fmt_be),
    .st_wdata (fmt_wdata),
    .ld_byte  (op_byte),
    .ld_lane  (op_lane),
    .ld_rdata (bus_rdata),
    .ld_data  (ld_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: an ack edge may immediately open the next access.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_access) state_nxt = ACCESS;
      ACCESS:  if (acc_done) state_nxt = start_access ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; stall releases combinationally on ack so the next op can enter.
  always_comb begin
    bus_req   = (state == ACCESS);
    mem_stall = (state == ACCESS) && !bus_ack;
  end

  // Wait counter: counts unacknowledged ACCESS cycles, cleared on every exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wait_cnt <= 8'd0;
    else if (state == ACCESS && !acc_done) wait_cnt <= wait_cnt + 8'd1;
    else                                 wait_cnt <= 8'd0;
  end

  // Capture the op and its bus request; held stable for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_byte      <= 1'b0;
      op_lane      <= LANE0;
      op_reg_write <= 1'b0;
      op_wreg      <= 5'd0;
      op_result    <= 32'd0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_be       <= 4'd0;
      bus_wdata    <= 32'd0;
    end else if (start_access) begin
      op_byte      <= ex_load_byte;
      op_lane      <= ex_result[1:0];
      op_reg_write <= ex_reg_write;
      op_wreg      <= ex_wreg;
      op_result    <= ex_result;
      bus_we       <= ex_mem_write;
      bus_addr     <= {ex_result[31:2], 2'b00};
      bus_be       <= fmt_be;
      bus_wdata    <= fmt_wdata;
    end
  end

  // Parking slot for a non-access op that arrives while a write-back is already due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld       <= 1'b0;
      pend_reg_write <= 1'b0;
      pend_wreg      <= 5'd0;
      pend_data      <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
      pend_mis       <= 1'b0;
`endif
    end else begin
      pend_vld <= direct && (acc_done || pend_vld);
      if (direct) begin
        pend_reg_write <= ex_reg_write && !bad_align;
        pend_wreg      <= ex_wreg;
        pend_data      <= ex_result;
`ifdef MEM_ALIGN_CHECK_EN
        pend_mis       <= bad_align;
`endif
      end
    end
  end

  // Write-back: finished access first, then a parked op, then a fresh non-access op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_wreg      <= 5'd0;
      wb_data      <= 32'd0;
      bus_err      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign     <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
      if (acc_done) begin
        wb_valid     <= 1'b1;
        wb_wreg      <= op_wreg;
        wb_reg_write <= bus_ack && !bus_we && op_reg_write;
        wb_data      <= (bus_ack && !bus_we) ? ld_data : op_result;
        bus_err      <= !bus_ack;
      end else if (pend_vld) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= pend_reg_write;
        wb_wreg      <= pend_wreg;
        wb_data      <= pend_data;
`ifdef MEM_ALIGN_CHECK_EN
        misalign     <= pend_mis;
`endif
      end else if (direct) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= ex_reg_write && !bad_align;
        wb_wreg      <= ex_wreg;
        wb_data      <= ex_result;
`ifdef MEM_ALIGN_CHECK_EN
        misalign     <= bad_align;
`endif
      end
    end
  end

`ifndef MEM_ALIGN_CHECK_EN
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Expected write-backs are queued when an op is driven and popped by the write-back monitor.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_result = 32'd0;
  logic [31:0] ex_mem_data = 32'd0;
  logic        ex_load_byte = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic [4:0]  ex_wreg = 5'd0;
  logic        mem_stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_wreg;
  logic [31:0] wb_data;
  logic        bus_err, misalign;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_mem_data(ex_mem_data),
    .ex_load_byte(ex_load_byte), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_wreg(ex_wreg),
    .mem_stall(mem_stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg), .wb_data(wb_data),
    .bus_err(bus_err), .misalign(misalign)
  );

  // Write-back monitor: every wb_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wb_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got wreg=%0d data=%h, required no write-back", wb_wreg, wb_data);
      end else begin
        e = sb.pop_front();
        if (wb_reg_write !== e.rw || wb_wreg !== e.wreg || wb_data !== e.data || bus_err !== e.err) begin
          fails++;
          $display("FAIL wb_check: got rw=%0b wreg=%0d data=%h err=%0b, required rw=%0b wreg=%0d data=%h err=%0b",
                   wb_reg_write, wb_wreg, wb_data, bus_err, e.rw, e.wreg, e.data, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_op(input logic rd, input logic wr, input logic byt, input logic [31:0] res,
                          input logic [31:0] data, input logic [4:0] wreg, input logic rw);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_load_byte = byt;
    ex_result = res; ex_mem_data = data; ex_wreg = wreg; ex_reg_write = rw;
  endtask

  task automatic clear_op();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_load_byte = 1'b0; ex_reg_write = 1'b0;
  endtask

  // Present one memory op, ack it after 'delay' unacknowledged cycles, report what the bus showed.
  task automatic run_access(input logic rd, input logic wr, input logic byt, input logic [31:0] addr,
                            input logic [31:0] data, input logic [4:0] wreg, input logic rw,
                            input int delay, input logic [31:0] rdata, output int stalls,
                            output logic [31:0] o_addr, output logic [31:0] o_wdata,
                            output logic [3:0] o_be, output logic o_we);
    @(posedge clk); #1;
    drive_op(rd, wr, byt, addr, data, wreg, rw);
    @(posedge clk); #1;
    clear_op();
    stalls = 0;
    o_addr = 32'd0; o_wdata = 32'd0; o_be = 4'd0; o_we = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin bus_ack = 1'b1; bus_rdata = rdata; end
      @(negedge clk);
      if (i == 0) begin o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be; o_we = bus_we; end
      if (mem_stall) stalls++;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus_req !== 1'b0 || mem_stall !== 1'b0 || wb_valid !== 1'b0 || bus_err !== 1'b0 || misalign !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got req=%0b stall=%0b wbv=%0b err=%0b mis=%0b, required all 0",
               bus_req, mem_stall, wb_valid, bus_err, misalign);
    end
    tests++;
    if (wb_data !== 32'd0 || wb_wreg !== 5'd0 || bus_addr !== 32'd0 || bus_be !== 4'd0 || bus_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: got wb_data=%h wreg=%0d addr=%h be=%b we=%0b, required all 0",
               wb_data, wb_wreg, bus_addr, bus_be, bus_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic req_seen = 1'b0;
    sb.push_back(exp_t'{1'b1, 5'd3, 32'h0000_1234, 1'b0});
    @(posedge clk); #1;
    drive_op(1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    if (bus_req) req_seen = 1'b1;
    @(posedge clk); #1;
    clear_op();
    @(negedge clk);
    if (bus_req) req_seen = 1'b1;
    tests++;
    if (wb_valid !== 1'b1) begin
      fails++;
      $display("FAIL alu_latency: got wb_valid=%0b, required 1", wb_valid);
    end
    @(negedge clk);
    if (bus_req) req_seen = 1'b1;
    tests++;
    if (req_seen !== 1'b0 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL alu_no_bus: got req_seen=%0b wb_valid=%0b, required 0 0", req_seen, wb_valid);
    end
  endtask

  task automatic test_store();
    int st; logic [31:0] a, w; logic [3:0] be; logic we;
    sb.push_back(exp_t'{1'b0, 5'd4, 32'h0000_0102, 1'b0});
    run_access(1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0000_00AB, 5'd4, 1'b1, 3, 32'h0, st, a, w, be, we);
    tests++;
    if (be !== 4'b0100 || w !== 32'hABAB_ABAB || a !== 32'h0000_0100 || we !== 1'b1) begin
      fails++;
      $display("FAIL sb_bus: got be=%b wdata=%h addr=%h we=%0b, required 0100 abababab 00000100 1", be, w, a, we);
    end
    tests++;
    if (st != 3) begin
      fails++;
      $display("FAIL sb_stall: got %0d stall cycles, required 3", st);
    end
    sb.push_back(exp_t'{1'b0, 5'd6, 32'h0000_0108, 1'b0});
    run_access(1'b0, 1'b1, 1'b0, 32'h0000_0108, 32'h1357_9BDF, 5'd6, 1'b1, 0, 32'h0, st, a, w, be, we);
    tests++;
    if (be !== 4'b1111 || w !== 32'h1357_9BDF || a !== 32'h0000_0108 || st != 0) begin
      fails++;
      $display("FAIL sw_bus: got be=%b wdata=%h addr=%h stalls=%0d, required 1111 13579bdf 00000108 0", be, w, a, st);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load();
    int st; logic [31:0] a, w; logic [3:0] be; logic we;
    sb.push_back(exp_t'{1'b1, 5'd5, 32'hFFFF_FF80, 1'b0});
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'h0, 5'd5, 1'b1, 1, 32'h80FF_FFFF, st, a, w, be, we);
    tests++;
    if (be !== 4'b1000 || a !== 32'h0000_0200 || we !== 1'b0) begin
      fails++;
      $display("FAIL lb_bus: got be=%b addr=%h we=%0b, required 1000 00000200 0", be, a, we);
    end
    sb.push_back(exp_t'{1'b1, 5'd5, 32'h0000_007F, 1'b0});
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'h0, 5'd5, 1'b1, 0, 32'h7F00_0000, st, a, w, be, we);
    sb.push_back(exp_t'{1'b1, 5'd7, 32'hFFFF_FF85, 1'b0});
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_0201, 32'h0, 5'd7, 1'b1, 0, 32'h0000_8500, st, a, w, be, we);
    sb.push_back(exp_t'{1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0});
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 5'd8, 1'b1, 2, 32'hDEAD_BEEF, st, a, w, be, we);
    tests++;
    if (be !== 4'b1111 || st != 2) begin
      fails++;
      $display("FAIL lw_bus: got be=%b stalls=%0d, required 1111 2", be, st);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    sb.push_back(exp_t'{1'b0, 5'd9, 32'h0000_0400, 1'b1});
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 5'd9, 1'b1);
    @(posedge clk); #1;
    clear_op();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus_req) break;
      req_cycles++;
    end
    tests++;
    if (req_cycles != 15) begin
      fails++;
      $display("FAIL timeout_len: got %0d request cycles, required 15", req_cycles);
    end
    tests++;
    if (bus_req !== 1'b0 || bus_err !== 1'b1 || mem_stall !== 1'b0 || wb_valid !== 1'b1) begin
      fails++;
      $display("FAIL timeout_abort: got req=%0b err=%0b stall=%0b wbv=%0b, required 0 1 0 1",
               bus_req, bus_err, mem_stall, wb_valid);
    end
    sb.push_back(exp_t'{1'b1, 5'd10, 32'h0000_0055, 1'b0});
    drive_op(1'b0, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd10, 1'b1);
    @(posedge clk); #1;
    clear_op();
    @(negedge clk);
    tests++;
    if (wb_valid !== 1'b1 || bus_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_next: got wbv=%0b err=%0b, required 1 0", wb_valid, bus_err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    sb.push_back(exp_t'{1'b1, 5'd11, 32'h1111_1111, 1'b0});
    sb.push_back(exp_t'{1'b1, 5'd12, 32'h2222_2222, 1'b0});
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 5'd11, 1'b1);
    @(posedge clk); #1;
    clear_op();
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    drive_op(1'b1, 1'b0, 1'b0, 32'h0000_0504, 32'h0, 5'd12, 1'b1);
    @(negedge clk);
    tests++;
    if (mem_stall !== 1'b0) begin
      fails++;
      $display("FAIL b2b_stall: got mem_stall=%0b on ack cycle, required 0", mem_stall);
    end
    @(posedge clk); #1;
    clear_op();
    bus_rdata = 32'h2222_2222;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0504 || wb_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_nobubble: got req=%0b addr=%h wbv=%0b, required 1 00000504 1", bus_req, bus_addr, wb_valid);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    sb.push_back(exp_t'{1'b1, 5'd13, 32'h3333_3333, 1'b0});
    sb.push_back(exp_t'{1'b1, 5'd14, 32'h0000_0077, 1'b0});
    drive_op(1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 5'd13, 1'b1);
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h3333_3333;
    drive_op(1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd14, 1'b1);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    clear_op();
    @(negedge clk);
    tests++;
    if (wb_valid !== 1'b1 || wb_wreg !== 5'd13) begin
      fails++;
      $display("FAIL b2b_order1: got wbv=%0b wreg=%0d, required 1 13", wb_valid, wb_wreg);
    end
    @(negedge clk);
    tests++;
    if (wb_valid !== 1'b1 || wb_wreg !== 5'd14) begin
      fails++;
      $display("FAIL b2b_order2: got wbv=%0b wreg=%0d, required 1 14", wb_valid, wb_wreg);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 5'd15, 1'b1);
    @(posedge clk); #1;
    clear_op();
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: got bus_req=%0b, required 1", bus_req);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (bus_req !== 1'b0 || mem_stall !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_drop: got req=%0b stall=%0b, required 0 0", bus_req, mem_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b0 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_lost: got req=%0b wbv=%0b, required 0 0", bus_req, wb_valid);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
    logic req_seen = 1'b0;
    sb.push_back(exp_t'{1'b0, 5'd16, 32'h0000_0006, 1'b0});
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0, 5'd16, 1'b1);
    @(posedge clk); #1;
    clear_op();
    @(negedge clk);
    if (bus_req) req_seen = 1'b1;
    tests++;
    if (misalign !== 1'b1 || wb_valid !== 1'b1 || req_seen !== 1'b0) begin
      fails++;
      $display("FAIL misalign_trap: got mis=%0b wbv=%0b req=%0b, required 1 1 0", misalign, wb_valid, req_seen);
    end
    @(negedge clk);
    tests++;
    if (misalign !== 1'b0 || bus_req !== 1'b0) begin
      fails++;
      $display("FAIL misalign_pulse: got mis=%0b req=%0b, required 0 0", misalign, bus_req);
    end
`else
    int st; logic [31:0] a, w; logic [3:0] be; logic we;
    sb.push_back(exp_t'{1'b1, 5'd16, 32'hCAFE_F00D, 1'b0});
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0, 5'd16, 1'b1, 1, 32'hCAFE_F00D, st, a, w, be, we);
    tests++;
    if (a !== 32'h0000_0004 || be !== 4'b1111 || misalign !== 1'b0) begin
      fails++;
      $display("FAIL misalign_pass: got addr=%h be=%b mis=%0b, required 00000004 1111 0", a, be, misalign);
    end
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_misalign();
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d write-backs missing, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
